bcd_counter_display: RTL and testbench



---
 rtl/bcd_counter_display.sv | 169 ++++++++++++++++
 tb/tb_bcd_counter_display.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_display.sv
// BCD up/down counter with prescaled stepping and a multiplexed common-anode 7-segment driver.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_counter_display #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 12_500_000,
    parameter int SCAN_DIV   = 50_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    wrap,
    output logic [7:0]              segmentos,
    output logic [NUM_DIGITS-1:0]   sel_seg
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         presc;
    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         idx;
    logic [W-1:0]          count_inc;
    logic [W-1:0]          count_dec;
    logic [W-1:0]          load_clamped;
    logic                  inc_carry;
    logic                  dec_borrow;
    logic [3:0]            digit_val;
    logic [NUM_DIGITS-1:0] sel_next;
    logic [7:0]            seg_next;

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 8'hC0;
            4'd1:    seg_decode = 8'hF9;
            4'd2:    seg_decode = 8'hA4;
            4'd3:    seg_decode = 8'hB0;
            4'd4:    seg_decode = 8'h99;
            4'd5:    seg_decode = 8'h92;
            4'd6:    seg_decode = 8'h82;
            4'd7:    seg_decode = 8'hF8;
            4'd8:    seg_decode = 8'h80;
            4'd9:    seg_decode = 8'h90;
            default: seg_decode = 8'hFF;
        endcase
    endfunction

    // Ripple carry/borrow across digits; the final carry/borrow is the wrap condition.
    always_comb begin
        count_inc  = count_bcd;
        count_dec  = count_bcd;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (inc_carry) begin
                if (count_bcd[i*4 +: 4] == 4'd9) begin
                    count_inc[i*4 +: 4] = 4'd0;
                end else begin
                    count_inc[i*4 +: 4] = count_bcd[i*4 +: 4] + 4'd1;
                    inc_carry = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (count_bcd[i*4 +: 4] == 4'd0) begin
                    count_dec[i*4 +: 4] = 4'd9;
                end else begin
                    count_dec[i*4 +: 4] = count_bcd[i*4 +: 4] - 4'd1;
                    dec_borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin
        load_clamped = load_val;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_val[i*4 +: 4] > 4'd9) begin
                load_clamped[i*4 +: 4] = 4'd9;
            end
        end
    end

    // Load wins over a step and restarts the prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_bcd <= '0;
            wrap      <= 1'b0;
            presc     <= '0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count_bcd <= load_clamped;
                presc     <= '0;
            end else if (en) begin
                if (presc == TICK_LAST) begin
                    presc     <= '0;
                    count_bcd <= up_dn ? count_inc : count_dec;
                    wrap      <= up_dn ? inc_carry : dec_borrow;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    always_comb begin
        digit_val = 4'd0;
        sel_next  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                digit_val   = count_bcd[i*4 +: 4];
                sel_next[i] = 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero;
    logic blank;

    // A digit is blanked when it and every digit above it are zero.
    always_comb begin
        upper_zero = 1'b1;
        blank      = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero & (count_bcd[i*4 +: 4] == 4'd0);
            if (idx == IW'(i)) begin
                blank = upper_zero;
            end
        end
    end

    assign seg_next = blank ? 8'hFF : seg_decode(digit_val);
`else
    assign seg_next = seg_decode(digit_val);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            segmentos <= 8'hFF;
            sel_seg   <= '1;
        end else begin
            segmentos <= seg_next;
            sel_seg   <= sel_next;
        end
    end

endmodule

// File: tb/tb_bcd_counter_display.sv
// Self-checking bench for bcd_counter_display: vector table, hand sequences and random stimulus
// compared every cycle against an integer-arithmetic reference model.
module tb_bcd_counter_display;

    localparam int ND = 3;
    localparam int TD = 4;
    localparam int SD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          up_dn;
    logic          load;
    logic [11:0]   load_val;
    logic [11:0]   count_bcd;
    logic          wrap;
    logic [7:0]    segmentos;
    logic [2:0]    sel_seg;

    always #5 clk = ~clk;

    bcd_counter_display #(
        .NUM_DIGITS(ND),
        .TICK_DIV  (TD),
        .SCAN_DIV  (SD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count_bcd(count_bcd),
        .wrap     (wrap),
        .segmentos(segmentos),
        .sel_seg  (sel_seg)
    );

    int tests    = 0;
    int failures = 0;
    int wrap_seen;

    int         m_count;
    int         m_presc;
    int         m_scan;
    int         m_idx;
    logic       m_wrap;
    logic [7:0] m_seg;
    logic [2:0] m_sel;
    logic [7:0] seg_tab [10];

    typedef struct {
        logic        en;
        logic        up;
        logic        ld;
        logic [11:0] lv;
        int          cycles;
        logic [11:0] exp_count;
        int          exp_wraps;
    } vec_t;

    vec_t vecs[$];

    function automatic int pow10(input int e);
        int p;
        p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r = '0;
        for (int i = 0; i < ND; i++) r[i*4 +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int from_bcd_clamped(input logic [11:0] v);
        int s;
        int d;
        s = 0;
        for (int i = 0; i < ND; i++) begin
            d = int'(v[i*4 +: 4]);
            if (d > 9) d = 9;
            s = s + d * pow10(i);
        end
        return s;
    endfunction

    function automatic vec_t mk(input logic e, input logic u, input logic l, input logic [11:0] lv,
                                input int cyc, input logic [11:0] ec, input int ew);
        vec_t v;
        v.en = e; v.up = u; v.ld = l; v.lv = lv;
        v.cycles = cyc; v.exp_count = ec; v.exp_wraps = ew;
        return v;
    endfunction

    task automatic model_reset();
        m_count = 0; m_presc = 0; m_scan = 0; m_idx = 0;
        m_wrap = 1'b0; m_seg = 8'hFF; m_sel = 3'b111;
    endtask

    task automatic model_step();
        int pw;
        pw = pow10(m_idx);
        m_sel = 3'b111;
        m_sel[m_idx] = 1'b0;
        m_seg = seg_tab[(m_count / pw) % 10];
`ifdef LEADING_ZERO_BLANK_EN
        if (m_idx > 0 && m_count < pw) m_seg = 8'hFF;
`endif
        if (m_scan == SD - 1) begin
            m_scan = 0;
            m_idx  = (m_idx + 1) % ND;
        end else begin
            m_scan = m_scan + 1;
        end
        m_wrap = 1'b0;
        if (load) begin
            m_count = from_bcd_clamped(load_val);
            m_presc = 0;
        end else if (en) begin
            if (m_presc == TD - 1) begin
                m_presc = 0;
                if (up_dn) begin
                    m_wrap  = (m_count == 999);
                    m_count = (m_count + 1) % 1000;
                end else begin
                    m_wrap  = (m_count == 0);
                    m_count = (m_count + 999) % 1000;
                end
            end else begin
                m_presc = m_presc + 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output();
        check("count_bcd", count_bcd, to_bcd(m_count));
        check("wrap", {11'b0, wrap}, {11'b0, m_wrap});
        check("segmentos", {4'b0, segmentos}, {4'b0, m_seg});
        check("sel_seg", {9'b0, sel_seg}, {9'b0, m_sel});
        if (wrap === 1'b1) wrap_seen++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            check_output();
        end
    endtask

    task automatic apply_stimulus(input logic e, input logic u, input logic l, input logic [11:0] lv);
        en = e; up_dn = u; load = l; load_val = lv;
    endtask

    initial begin
        logic [7:0] exp_seg;

        seg_tab[0] = 8'hC0; seg_tab[1] = 8'hF9; seg_tab[2] = 8'hA4; seg_tab[3] = 8'hB0;
        seg_tab[4] = 8'h99; seg_tab[5] = 8'h92; seg_tab[6] = 8'h82; seg_tab[7] = 8'hF8;
        seg_tab[8] = 8'h80; seg_tab[9] = 8'h90;

        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 12'h000, 12,  12'h000, 0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 12'h000, 4,   12'h001, 0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 12'h000, 36,  12'h010, 0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 12'h099, 1,   12'h099, 0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 12'h000, 4,   12'h100, 0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 12'h999, 1,   12'h999, 0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 12'h000, 4,   12'h000, 1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'h000, 4,   12'h999, 1));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 12'h000, 3,   12'h999, 0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 12'h1F5, 1,   12'h195, 0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 12'h000, 3,   12'h195, 0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 12'h000, 1,   12'h196, 0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 12'h000, 2,   12'h196, 0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 12'h000, 10,  12'h196, 0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 12'h000, 1,   12'h196, 0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 12'h000, 1,   12'h197, 0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 12'h100, 1,   12'h100, 0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'h000, 4,   12'h099, 0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'h000, 400, 12'h999, 1));

        rst = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b0, 12'h000);
        model_reset();
        #1;
        check_output();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k]) begin
            apply_stimulus(vecs[k].en, vecs[k].up, vecs[k].ld, vecs[k].lv);
            wrap_seen = 0;
            tick(vecs[k].cycles);
            check("vec_count", count_bcd, vecs[k].exp_count);
            check("vec_wraps", 12'(wrap_seen), 12'(vecs[k].exp_wraps));
        end

        // Count 042 held: check each scanned digit against fixed segment codes.
        apply_stimulus(1'b0, 1'b1, 1'b1, 12'h042);
        tick(1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 12'h000);
        tick(1);
        for (int c = 0; c < 6; c++) begin
            tick(1);
            case (sel_seg)
                3'b110:  exp_seg = 8'hA4;
                3'b101:  exp_seg = 8'h99;
`ifdef LEADING_ZERO_BLANK_EN
                default: exp_seg = 8'hFF;
`else
                default: exp_seg = 8'hC0;
`endif
            endcase
            check("disp042", {4'b0, segmentos}, {4'b0, exp_seg});
        end

        // Asynchronous reset mid-scan: outputs must clear before the next clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_count", count_bcd, 12'h000);
        check("async_wrap", {11'b0, wrap}, 12'h000);
        check("async_seg", {4'b0, segmentos}, 12'h0FF);
        check("async_sel", {9'b0, sel_seg}, 12'h007);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick(12);

        for (int c = 0; c < 3000; c++) begin
            if (c % 25 == 0) up_dn = 1'($urandom_range(0, 1));
            en   = ($urandom_range(0, 9) != 0);
            load = ($urandom_range(0, 59) == 0);
            case ($urandom_range(0, 3))
                0:       load_val = 12'h999;
                1:       load_val = 12'h000;
                default: load_val = 12'($urandom);
            endcase
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
